// File: rtl/fetch_stage.sv
// Instruction fetch: program-load port, PC sequencing, and the IF/ID register.
// Latency: one cycle from PC to IF/ID; the first fetch comes two edges after the load strobe drops.
// Backpressure: stall freezes PC and IF/ID; a branch overrides stall and inserts a bubble.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'd32,
    parameter int          IMEM_DEPTH = 64,
    parameter int          IDX_W      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enable_fm,
    input  logic [31:0] write_addr_fm,
    input  logic [15:0] write_data_fm,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [15:0] instruction,
    output logic [31:0] pc_out,
    output logic        valid,
    output logic        state_out
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [31:0] pc;
        logic        valid;
    } ifid_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    ifid_t       ifid_q, ifid_d;
    logic [15:0] fetch_dat;

    logic [15:0] mem [IMEM_DEPTH];

    // Memory is deliberately outside the reset domain so a program survives a reset.
    always_ff @(posedge clk) begin
        if (write_enable_fm) begin
            mem[write_addr_fm[IDX_W-1:0]] <= write_data_fm;
        end
    end

    assign fetch_dat = mem[pc_q[IDX_W-1:0]];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        case (state_q)
            LOAD: begin
                pc_d         = RESET_PC;
                ifid_d.instr = 16'h0000;
                ifid_d.valid = 1'b0;
                if (!write_enable_fm) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (write_enable_fm) begin
                    state_d      = LOAD;
                    pc_d         = RESET_PC;
                    ifid_d.instr = 16'h0000;
                    ifid_d.valid = 1'b0;
                end else if (branch_taken) begin
                    // Bubble keeps the previous pc_out; only instr/valid are cleared.
                    pc_d         = branch_target;
                    ifid_d.instr = 16'h0000;
                    ifid_d.valid = 1'b0;
                end else if (!stall) begin
                    ifid_d.instr = fetch_dat;
                    ifid_d.pc    = pc_q;
                    ifid_d.valid = 1'b1;
                    pc_d         = pc_q + 32'd1;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
            pc_q    <= RESET_PC;
            ifid_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
        end
    end

    assign instruction = ifid_q.instr;
    assign pc_out      = ifid_q.pc;
    assign valid       = ifid_q.valid;
    assign state_out   = state_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 16-bit pipelined processor. It holds the instruction memory, which is loaded through the fm write port, and the program counter. It drives the IF/ID pipeline register that the decode stage consumes, and it handles stall, branch redirect and program-load sequencing.

Parameters:
RESET_PC, 32, PC value after reset or reload (program load base address 0x20).
IMEM_DEPTH, 64, instruction memory words; must be a power of two.
IDX_W, 6, log2(IMEM_DEPTH); memory index = address[IDX_W-1:0].

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
write_enable_fm  input  1  program-load write strobe
write_addr_fm  input  32  program-load word address
write_data_fm  input  16  program-load instruction word
stall  input  1  from hazard unit; freeze PC and IF/ID
branch_taken  input  1  redirect request from later stage
branch_target  input  32  redirect PC
instruction  output  16  IF/ID instruction to decode
pc_out  output  32  IF/ID PC of that instruction
valid  output  1  IF/ID holds a real instruction
state_out  output  1  0 = LOAD, 1 = RUN (debug)

Behaviour:
- Memory: synchronous write when write_enable_fm=1: mem[write_addr_fm[IDX_W-1:0]] <= write_data_fm. Upper address bits are ignored (aliasing).
- Memory read is combinational: mem[PC[IDX_W-1:0]].
- Memory contents are not cleared by reset, so a program loaded before reset survives.
- Writes are accepted in any state and are independent of reset.
- FSM states:
  - LOAD: fetch suspended.
  - RUN: fetching.
- Reset (synchronous): state <= LOAD, PC <= RESET_PC, instruction <= 16'h0000, pc_out <= 0, valid <= 0. state_out therefore reads 0 after reset.
- LOAD:
  - PC held at RESET_PC; IF/ID held at instruction=0, valid=0.
  - Stays in LOAD while write_enable_fm=1.
  - On the first edge sampling write_enable_fm=0 -> RUN. No fetch occurs on that edge.
- RUN, per edge, in priority order:
  1. write_enable_fm=1: state <= LOAD, PC <= RESET_PC, valid <= 0, instruction <= 0. The write itself still occurs.
  2. branch_taken=1: PC <= branch_target, valid <= 0, instruction <= 0 (bubble), pc_out unchanged. Branch overrides stall.
  3. stall=1: PC, instruction, pc_out and valid all held.
  4. Otherwise: instruction <= mem[PC], pc_out <= PC, valid <= 1, PC <= PC+1.
- Latency: one cycle from PC to IF/ID. The first valid instruction appears two edges after write_enable_fm falls (one edge LOAD->RUN, one edge fetch).
- PC arithmetic is 32-bit and wraps 0xFFFFFFFF -> 0. The memory index wraps modulo IMEM_DEPTH.
- Read and write of the same address on the same edge: the fetch returns the old word.
- branch_taken and stall sampled in LOAD are ignored.
- Reset asserted mid-RUN overrides everything on that edge.

Test Plan:
- Load and run:
  - Stimulus: reset=1 with write_enable_fm=1; write 16'h553F @32, 16'h2ABF @33; release reset, then drop write_enable_fm.
  - Response: next edge state_out=1, valid=0; following edge instruction=553F, pc_out=32, valid=1; next edge 2ABF, pc_out=33.
- Stall:
  - Stimulus: stall=1 for 2 cycles while instruction=553F.
  - Response: instruction=553F, pc_out=32, valid=1 held; after release, 2ABF/33 appears on the next edge.
- Branch:
  - Stimulus: branch_taken=1, branch_target=40 (mem[40]=16'h7E3F).
  - Response: next edge valid=0, instruction=0; following edge instruction=7E3F, pc_out=40, valid=1.
- Branch plus stall:
  - Stimulus: stall=1 and branch_taken=1 together, target=32.
  - Response: the redirect occurs and a bubble is inserted; 553F/32 follows on the next unstalled edge.
- Reload mid-run:
  - Stimulus: write_enable_fm=1 during RUN, writing 16'h1234 @32.
  - Response: state_out=0, valid=0, PC=32; after write_enable_fm drops, the first fetched instruction=1234 at pc_out=32.
- Aliasing and reset preservation:
  - Stimulus: write 16'hBEEF at address 96 (aliases index 32); pulse reset without rewriting memory; run.
  - Response: the first fetched instruction=BEEF, pc_out=32.
